y86_instr_encoder: RTL and testbench

Inverse of the pipeline fetch decoder. Accepts one decoded Y86-64 instruction per handshake (icode, ifun, rA, rB, valC) and serializes it, one byte per cycle, into the 256-byte instruction memory. It uses the same byte layout that fetch decodes. It sits between the program loader/testbench host and the instruction memory write port, so programs are built from fields instead of pre-assembled data files.

---
 rtl/y86_instr_encoder.sv | 171 +++++++++++++++++
 tb/tb_y86_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder: serialises one decoded Y86-64 instruction per handshake
// into byte writes for the instruction memory, using the byte layout that
// fetch decodes. Byte 0 = {icode, ifun}, optional {rA, rB}, then valC
// little-endian.
//
// state | meaning
// IDLE  | waiting for an instruction or a pointer load; no writes
// EMIT  | one instruction byte on the write port per cycle
module y86_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic [ADDR_W-1:0] next_addr,
  output logic [1:0]        err_stat
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ADR  = 2'd2;
  localparam logic [1:0] ERR_INS  = 2'd3;

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_CMOVXX = 4'h2;
  localparam logic [3:0] IC_IRMOVQ = 4'h3;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_OPQ    = 4'h6;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   MEM_SIZE = {1'b1, {ADDR_W{1'b0}}};

  // Encoded length in bytes; 0 marks an icode with no encoding.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      IC_HALT, IC_NOP, IC_RET:                  instr_len = 4'd1;
      IC_CMOVXX, IC_OPQ, IC_PUSHQ, IC_POPQ:     instr_len = 4'd2;
      IC_JXX, IC_CALL:                          instr_len = 4'd9;
      IC_IRMOVQ, IC_RMMOVQ, IC_MRMOVQ:          instr_len = 4'd10;
      default:                                  instr_len = 4'd0;
    endcase
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  // Fields held for the body bytes; byte 0 goes out at accept time, so
  // ifun never needs to be kept.
  logic [3:0]        lat_icode;
  logic [3:0]        lat_ra;
  logic [3:0]        lat_rb;
  logic [63:0]       lat_valc;
  logic [3:0]        lat_len;

  // Index of the next byte to drive onto the write port.
  logic [3:0]        idx;

  logic [3:0]        in_len;
  logic [ADDR_W:0]   end_addr;
  logic              in_fits;
  logic [2:0]        valc_k;
  logic [7:0]        body_byte;

  assign in_len    = instr_len(in_icode);
  assign end_addr  = {1'b0, ptr} + {{(ADDR_W-3){1'b0}}, in_len};
  assign in_fits   = (end_addr <= MEM_SIZE);
  assign in_ready  = (state == IDLE) && (err_stat == ERR_NONE) && !addr_load;
  assign next_addr = ptr;

  // Select body byte idx (1..9) of the latched instruction.
  always_comb begin
    valc_k    = 3'd0;
    body_byte = {lat_ra, lat_rb};
    if (lat_icode == IC_JXX || lat_icode == IC_CALL) begin
      // valC directly follows the opcode byte
      valc_k    = idx[2:0] - 3'd1;
      body_byte = lat_valc[{valc_k, 3'b000} +: 8];
    end else if (idx != 4'd1) begin
      // only the 10-byte forms reach idx >= 2: valC after the register byte
      valc_k    = idx[2:0] - 3'd2;
      body_byte = lat_valc[{valc_k, 3'b000} +: 8];
    end
  end

  // Control FSM with registered write-port outputs. Byte 0 is launched on
  // the accept edge so that EMIT lasts exactly one cycle per byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      err_stat  <= ERR_NONE;
      lat_icode <= 4'h0;
      lat_ra    <= 4'h0;
      lat_rb    <= 4'h0;
      lat_valc  <= 64'h0;
      lat_len   <= 4'd0;
      idx       <= 4'd0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_load) begin
            ptr      <= addr_value;
            err_stat <= ERR_NONE;
          end else if (in_valid && in_ready) begin
            if (in_len == 4'd0) begin
              err_stat <= ERR_INS;
            end else if (!in_fits) begin
              err_stat <= ERR_ADR;
            end else begin
              lat_icode <= in_icode;
              lat_ra    <= in_rA;
              lat_rb    <= in_rB;
              lat_valc  <= in_valC;
              lat_len   <= in_len;
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= {in_icode, in_ifun};
              done      <= (in_len == 4'd1);
              ptr       <= ptr + PTR_ONE;
              idx       <= 4'd1;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (idx == lat_len) begin
            state <= IDLE;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= body_byte;
            done      <= (idx == lat_len - 4'd1);
            ptr       <= ptr + PTR_ONE;
            idx       <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: table of instructions with expected error and
// pointer, expected memory writes queued and matched by a write-port monitor,
// plus hand sequences for error recovery, load priority and reset abort.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        addr_load = 1'b0;
  logic [7:0]  addr_value = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_icode = 4'h0;
  logic [3:0]  in_ifun = 4'h0;
  logic [3:0]  in_rA = 4'h0;
  logic [3:0]  in_rB = 4'h0;
  logic [63:0] in_valC = 64'h0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        done;
  logic [7:0]  next_addr;
  logic [1:0]  err_stat;

  y86_instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .addr_load(addr_load), .addr_value(addr_value),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode),
    .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .next_addr(next_addr), .err_stat(err_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_load;
    logic [7:0]  load_val;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [1:0]  exp_err;
    logic [7:0]  exp_next;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  wr_t        sb[$];
  vec_t       vecs[$];
  logic [7:0] tbmem [256];
  logic [7:0] mb [10];
  logic [7:0] model_ptr = 8'h00;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  task automatic build_model(input logic [3:0] ic, input logic [3:0] ifn,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] valc);
    logic [63:0] t;
    for (int i = 0; i < 10; i++) mb[i] = 8'h00;
    mb[0] = {ic, ifn};
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) mb[1] = {ra, rb};
    for (int i = 0; i < 8; i++) begin
      t = valc >> (8 * i);
      if (ic == 4'h7 || ic == 4'h8) mb[1 + i] = t[7:0];
      if (ic inside {4'h3, 4'h4, 4'h5}) mb[2 + i] = t[7:0];
    end
  endtask

  // Write-port monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got write 0x%0h@0x%0h, expected no write", mem_wdata, mem_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_done", done, e.last);
      end
    end else if (done === 1'b1) begin
      check("done_without_we", done, 1'b0);
    end
  end

  always @(posedge clk) if (mem_we === 1'b1) tbmem[mem_addr] <= mem_wdata;

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    addr_load = 1'b1;
    addr_value = v;
    @(negedge clk);
    addr_load = 1'b0;
    #1;
    model_ptr = v;
  endtask

  task automatic send(input vec_t v, input int k);
    int len, cnt, busy_exp;
    logic [8:0] endp;
    if (v.do_load) do_load(v.load_val);
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("v%0d_ready_before", k), in_ready, 1'b1);
    build_model(v.icode, v.ifun, v.ra, v.rb, v.valc);
    len = model_len(v.icode);
    endp = {1'b0, model_ptr} + 9'(len);
    busy_exp = 0;
    if (len != 0 && endp <= 9'd256) begin
      for (int i = 0; i < len; i++)
        sb.push_back('{model_ptr + 8'(i), mb[i], (i == len - 1)});
      model_ptr = model_ptr + 8'(len);
      busy_exp = len;
    end
    in_valid = 1'b1;
    in_icode = v.icode;
    in_ifun  = v.ifun;
    in_rA    = v.ra;
    in_rB    = v.rb;
    in_valC  = v.valc;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (in_ready !== 1'b1 && err_stat == 2'd0 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check($sformatf("v%0d_busy_cycles", k), cnt, busy_exp);
    check($sformatf("v%0d_err_stat", k), err_stat, v.exp_err);
    check($sformatf("v%0d_next_addr", k), next_addr, v.exp_next);
    check($sformatf("v%0d_writes_left", k), sb.size(), 0);
    if (v.exp_err != 2'd0) check($sformatf("v%0d_ready_blocked", k), in_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_err_stat", err_stat, 2'd0);
    check("rst_next_addr", next_addr, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);

    //              load  val     ic     ifn    rA     rB     valC                    err   next
    vecs.push_back('{1'b0, 8'd0,   4'h3, 4'h0, 4'hF, 4'h2, 64'h100,                 2'd0, 8'd10});
    vecs.push_back('{1'b0, 8'd0,   4'h7, 4'h3, 4'h5, 4'h5, 64'h40,                  2'd0, 8'd19});
    vecs.push_back('{1'b1, 8'd0,   4'h1, 4'h0, 4'h0, 4'h0, 64'h0,                   2'd0, 8'd1});
    vecs.push_back('{1'b0, 8'd0,   4'h6, 4'h0, 4'h0, 4'h3, 64'h0,                   2'd0, 8'd3});
    vecs.push_back('{1'b0, 8'd0,   4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   2'd0, 8'd4});
    vecs.push_back('{1'b1, 8'd250, 4'h4, 4'h0, 4'h1, 4'h2, 64'h8,                   2'd2, 8'd250});
    vecs.push_back('{1'b1, 8'd246, 4'h4, 4'h0, 4'h3, 4'h4, 64'h1122334455667788,    2'd0, 8'd0});
    vecs.push_back('{1'b1, 8'd100, 4'h5, 4'h0, 4'h6, 4'h7, 64'hDEADBEEF,            2'd0, 8'd110});
    vecs.push_back('{1'b0, 8'd0,   4'h8, 4'h0, 4'h9, 4'h9, 64'h1234,                2'd0, 8'd119});
    vecs.push_back('{1'b0, 8'd0,   4'h9, 4'h0, 4'h0, 4'h0, 64'hFFFF,                2'd0, 8'd120});
    vecs.push_back('{1'b0, 8'd0,   4'hA, 4'h0, 4'h3, 4'hF, 64'h0,                   2'd0, 8'd122});
    vecs.push_back('{1'b0, 8'd0,   4'hB, 4'h0, 4'h4, 4'hF, 64'h0,                   2'd0, 8'd124});
    vecs.push_back('{1'b0, 8'd0,   4'h2, 4'h1, 4'h1, 4'h2, 64'h0,                   2'd0, 8'd126});
    vecs.push_back('{1'b1, 8'd253, 4'h8, 4'h0, 4'h0, 4'h0, 64'hCAFE,                2'd2, 8'd253});
    vecs.push_back('{1'b1, 8'd200, 4'hF, 4'h0, 4'h0, 4'h0, 64'h0,                   2'd3, 8'd200});
    vecs.push_back('{1'b1, 8'd247, 4'h8, 4'h0, 4'h0, 4'h0, 64'hCAFE,                2'd0, 8'd0});
    vecs.push_back('{1'b1, 8'd4,   4'hC, 4'h0, 4'h0, 4'h0, 64'h0,                   2'd3, 8'd4});

    for (int k = 0; k < vecs.size(); k++) send(vecs[k], k);

    // Sticky INS error: offered instructions are ignored until addr_load.
    @(negedge clk);
    in_valid = 1'b1;
    in_icode = 4'h1;
    in_ifun  = 4'h0;
    repeat (3) @(negedge clk);
    check("ins_sticky_ready", in_ready, 1'b0);
    check("ins_sticky_ptr", next_addr, 8'd4);
    check("ins_sticky_err", err_stat, 2'd3);
    in_valid = 1'b0;
    @(negedge clk);
    addr_load = 1'b1;
    addr_value = 8'd4;
    #1;
    check("ready_low_during_load", in_ready, 1'b0);
    @(negedge clk);
    addr_load = 1'b0;
    #1;
    check("ins_cleared_err", err_stat, 2'd0);
    check("ins_cleared_ready", in_ready, 1'b1);
    check("ins_cleared_ptr", next_addr, 8'd4);

    // addr_load and in_valid together: load wins, nothing is accepted.
    @(negedge clk);
    addr_load = 1'b1;
    addr_value = 8'd50;
    in_valid = 1'b1;
    in_icode = 4'h1;
    @(negedge clk);
    addr_load = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("load_priority_ptr", next_addr, 8'd50);
    check("load_priority_ready", in_ready, 1'b1);
    model_ptr = 8'd50;

    // addr_load during EMIT is ignored.
    build_model(4'hA, 4'h0, 4'h3, 4'hF, 64'h0);
    sb.push_back('{8'd50, mb[0], 1'b0});
    sb.push_back('{8'd51, mb[1], 1'b1});
    in_valid = 1'b1;
    in_icode = 4'hA;
    in_ifun  = 4'h0;
    in_rA    = 4'h3;
    in_rB    = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    addr_load = 1'b1;
    addr_value = 8'd200;
    @(negedge clk);
    addr_load = 1'b0;
    repeat (2) @(negedge clk);
    check("emit_ignores_load_ptr", next_addr, 8'd52);
    check("emit_ignores_load_left", sb.size(), 0);

    // Reset in the middle of mrmovq: three bytes land, then writes stop.
    do_load(8'd0);
    build_model(4'h5, 4'h0, 4'h6, 4'h7, 64'h0807060504030201);
    for (int i = 0; i < 3; i++) sb.push_back('{8'(i), mb[i], 1'b0});
    @(negedge clk);
    in_valid = 1'b1;
    in_icode = 4'h5;
    in_ifun  = 4'h0;
    in_rA    = 4'h6;
    in_rB    = 4'h7;
    in_valC  = 64'h0807060504030201;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_mem_we", mem_we, 1'b0);
    check("abort_next_addr", next_addr, 8'd0);
    check("abort_err", err_stat, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    check("abort_byte0", tbmem[0], 8'h50);
    check("abort_byte1", tbmem[1], 8'h67);
    check("abort_byte2", tbmem[2], 8'h01);
    check("abort_byte3_kept", tbmem[3], 8'h00);
    check("abort_writes_left", sb.size(), 0);
    check("final_ptr", next_addr, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
